// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: arbitrates exceptions, mret and M-mode interrupts, strobes CSR capture, drives fetch redirect.
// Optional TRAP_VECTORED_MTVEC_EN: vectored mtvec mode offsets interrupt targets by 4*code.
module trap_sequencer #(
  parameter int XLEN                = 32,
  parameter int PC_BITWIDTH         = 32,
  parameter int EXCEPTION_CODE_BITS = 4
) (
  input  logic                           clk,
  input  logic                           sync_reset,
  input  logic                           exc_req,
  input  logic [EXCEPTION_CODE_BITS-1:0] exc_code,
  input  logic [PC_BITWIDTH-1:0]         exc_pc,
  input  logic [PC_BITWIDTH-1:0]         exc_addr,
  output logic                           exc_ack,
  input  logic                           mret_req,
  output logic                           mret_ack,
  input  logic                           instr_boundary,
  input  logic [PC_BITWIDTH-1:0]         next_pc,
  input  logic                           mie_in,
  input  logic                           mtie_in,
  input  logic                           meie_in,
  input  logic                           mtip_in,
  input  logic                           meip_in,
  input  logic [XLEN-1:0]                mtvec_in,
  input  logic [XLEN-1:0]                mepc_in,
  output logic                           activate_exception,
  output logic                           is_interrupt,
  output logic [EXCEPTION_CODE_BITS-1:0] exception_code,
  output logic [PC_BITWIDTH-1:0]         exception_PC,
  output logic [PC_BITWIDTH-1:0]         exception_addr,
  output logic                           csr_mret_active,
  output logic                           pipeline_hold,
  output logic                           redirect_valid,
  output logic [PC_BITWIDTH-1:0]         redirect_pc,
  input  logic                           redirect_ready
);

  typedef enum logic [1:0] {IDLE, TRAP, MRET, REDIRECT} state_t;

  state_t                           state_q, state_d;
  logic                             trap_active_q, trap_active_d;
  logic                             activate_exception_q, activate_exception_d;
  logic                             is_interrupt_q, is_interrupt_d;
  logic [EXCEPTION_CODE_BITS-1:0]   exception_code_q, exception_code_d;
  logic [PC_BITWIDTH-1:0]           exception_pc_q, exception_pc_d;
  logic [PC_BITWIDTH-1:0]           exception_addr_q, exception_addr_d;
  logic                             exc_ack_q, exc_ack_d;
  logic                             mret_ack_q, mret_ack_d;
  logic                             csr_mret_active_q, csr_mret_active_d;
  logic                             redirect_valid_q, redirect_valid_d;
  logic [PC_BITWIDTH-1:0]           redirect_pc_q, redirect_pc_d;

  logic            irq_ok, take_ext, take_tmr, idle_take;
  logic [XLEN-1:0] trap_base, trap_vec;

  assign irq_ok    = instr_boundary & mie_in & ~trap_active_q;
  assign take_ext  = irq_ok & meie_in & meip_in;
  assign take_tmr  = irq_ok & mtie_in & mtip_in;
  assign trap_base = {mtvec_in[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_MTVEC_EN
  always_comb begin
    trap_vec = trap_base;
    if (mtvec_in[1:0] == 2'b01 && is_interrupt_q)
      trap_vec = trap_base + (XLEN'(exception_code_q) << 2);
  end
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec_in[1:0];
  assign trap_vec = trap_base;
`endif

  always_comb begin
    state_d              = state_q;
    trap_active_d        = trap_active_q;
    activate_exception_d = 1'b0;
    is_interrupt_d       = is_interrupt_q;
    exception_code_d     = exception_code_q;
    exception_pc_d       = exception_pc_q;
    exception_addr_d     = exception_addr_q;
    exc_ack_d            = 1'b0;
    mret_ack_d           = 1'b0;
    csr_mret_active_d    = 1'b0;
    redirect_valid_d     = redirect_valid_q;
    redirect_pc_d        = redirect_pc_q;
    idle_take            = 1'b0;

    case (state_q)
      IDLE: begin
        // CSR strobes and acks are set here so they are registered in TRAP/MRET
        if (exc_req) begin
          idle_take            = 1'b1;
          state_d              = TRAP;
          activate_exception_d = 1'b1;
          exc_ack_d            = 1'b1;
          is_interrupt_d       = 1'b0;
          exception_code_d     = exc_code;
          exception_pc_d       = exc_pc;
          exception_addr_d     = exc_addr;
        end else if (mret_req) begin
          idle_take         = 1'b1;
          state_d           = MRET;
          mret_ack_d        = 1'b1;
          csr_mret_active_d = 1'b1;
        end else if (take_ext || take_tmr) begin
          idle_take            = 1'b1;
          state_d              = TRAP;
          activate_exception_d = 1'b1;
          is_interrupt_d       = 1'b1;
          exception_code_d     = take_ext ? EXCEPTION_CODE_BITS'(11) : EXCEPTION_CODE_BITS'(7);
          exception_pc_d       = next_pc;
          exception_addr_d     = '0;
        end
      end
      TRAP: begin
        trap_active_d    = 1'b1;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = trap_vec[PC_BITWIDTH-1:0];
        state_d          = REDIRECT;
      end
      MRET: begin
        trap_active_d    = 1'b0;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = mepc_in[PC_BITWIDTH-1:0];
        state_d          = REDIRECT;
      end
      REDIRECT: begin
        if (redirect_ready) begin
          redirect_valid_d = 1'b0;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q              <= IDLE;
      trap_active_q        <= 1'b0;
      activate_exception_q <= 1'b0;
      is_interrupt_q       <= 1'b0;
      exception_code_q     <= '0;
      exception_pc_q       <= '0;
      exception_addr_q     <= '0;
      exc_ack_q            <= 1'b0;
      mret_ack_q           <= 1'b0;
      csr_mret_active_q    <= 1'b0;
      redirect_valid_q     <= 1'b0;
      redirect_pc_q        <= '0;
    end else begin
      state_q              <= state_d;
      trap_active_q        <= trap_active_d;
      activate_exception_q <= activate_exception_d;
      is_interrupt_q       <= is_interrupt_d;
      exception_code_q     <= exception_code_d;
      exception_pc_q       <= exception_pc_d;
      exception_addr_q     <= exception_addr_d;
      exc_ack_q            <= exc_ack_d;
      mret_ack_q           <= mret_ack_d;
      csr_mret_active_q    <= csr_mret_active_d;
      redirect_valid_q     <= redirect_valid_d;
      redirect_pc_q        <= redirect_pc_d;
    end
  end

  // Hold is raised in the deciding IDLE cycle so the pipeline freezes before TRAP/MRET
  assign pipeline_hold      = ~sync_reset & ((state_q != IDLE) | idle_take);
  assign activate_exception = activate_exception_q;
  assign is_interrupt       = is_interrupt_q;
  assign exception_code     = exception_code_q;
  assign exception_PC       = exception_pc_q;
  assign exception_addr     = exception_addr_q;
  assign exc_ack            = exc_ack_q;
  assign mret_ack           = mret_ack_q;
  assign csr_mret_active    = csr_mret_active_q;
  assign redirect_valid     = redirect_valid_q;
  assign redirect_pc        = redirect_pc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: exceptions, interrupts, mret, priority, backpressure, reset, vectored mtvec.
module tb_trap_sequencer;
  logic        clk = 1'b0;
  logic        sync_reset;
  logic        exc_req, mret_req, instr_boundary, redirect_ready;
  logic [3:0]  exc_code;
  logic [31:0] exc_pc, exc_addr, next_pc, mtvec_in, mepc_in;
  logic        mie_in, mtie_in, meie_in, mtip_in, meip_in;
  logic        exc_ack, mret_ack, activate_exception, is_interrupt, csr_mret_active;
  logic        pipeline_hold, redirect_valid;
  logic [3:0]  exception_code;
  logic [31:0] exception_PC, exception_addr, redirect_pc;

  int errors = 0;
  int checks = 0;

  trap_sequencer dut (
    .clk(clk), .sync_reset(sync_reset),
    .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_addr(exc_addr), .exc_ack(exc_ack),
    .mret_req(mret_req), .mret_ack(mret_ack),
    .instr_boundary(instr_boundary), .next_pc(next_pc),
    .mie_in(mie_in), .mtie_in(mtie_in), .meie_in(meie_in), .mtip_in(mtip_in), .meip_in(meip_in),
    .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .activate_exception(activate_exception), .is_interrupt(is_interrupt),
    .exception_code(exception_code), .exception_PC(exception_PC), .exception_addr(exception_addr),
    .csr_mret_active(csr_mret_active), .pipeline_hold(pipeline_hold),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sync_reset = 1; exc_req = 0; mret_req = 0; instr_boundary = 0; redirect_ready = 1;
    exc_code = 0; exc_pc = 0; exc_addr = 0; next_pc = 0; mtvec_in = 32'h80; mepc_in = 0;
    mie_in = 0; mtie_in = 0; meie_in = 0; mtip_in = 0; meip_in = 0;
    step(); step();
    check_eq("rst_activate", activate_exception, 0);
    check_eq("rst_valid", redirect_valid, 0);
    check_eq("rst_hold", pipeline_hold, 0);
    check_eq("rst_exc_ack", exc_ack, 0);
    check_eq("rst_pc", redirect_pc, 0);
    sync_reset = 0;

    // Illegal instruction
    exc_req = 1; exc_code = 2; exc_pc = 32'h100; exc_addr = 32'hDEAD;
    #1 check_eq("ill_hold_decide", pipeline_hold, 1);
    step();
    check_eq("ill_activate", activate_exception, 1);
    check_eq("ill_is_int", is_interrupt, 0);
    check_eq("ill_code", exception_code, 2);
    check_eq("ill_pc", exception_PC, 32'h100);
    check_eq("ill_addr", exception_addr, 32'hDEAD);
    check_eq("ill_ack", exc_ack, 1);
    check_eq("ill_hold", pipeline_hold, 1);
    exc_req = 0;
    step();
    check_eq("ill_valid", redirect_valid, 1);
    check_eq("ill_redir_pc", redirect_pc, 32'h80);
    check_eq("ill_ack_pulse", exc_ack, 0);
    check_eq("ill_act_pulse", activate_exception, 0);
    step();
    check_eq("ill_idle_valid", redirect_valid, 0);
    check_eq("ill_idle_hold", pipeline_hold, 0);

    // Timer pending while trap_active: masked
    mie_in = 1; mtie_in = 1; mtip_in = 1; instr_boundary = 1; next_pc = 32'h204;
    #1 check_eq("mask_hold", pipeline_hold, 0);
    step();
    check_eq("mask_activate", activate_exception, 0);

    // mret, then the pending timer traps
    mepc_in = 32'h300; mret_req = 1;
    step();
    check_eq("mret_csr", csr_mret_active, 1);
    check_eq("mret_ack", mret_ack, 1);
    check_eq("mret_activate", activate_exception, 0);
    mret_req = 0;
    step();
    check_eq("mret_valid", redirect_valid, 1);
    check_eq("mret_pc", redirect_pc, 32'h300);
    check_eq("mret_ack_pulse", mret_ack, 0);
    check_eq("mret_csr_pulse", csr_mret_active, 0);
    step();
    check_eq("tmr_hold_decide", pipeline_hold, 1);
    step();
    check_eq("tmr_activate", activate_exception, 1);
    check_eq("tmr_is_int", is_interrupt, 1);
    check_eq("tmr_code", exception_code, 7);
    check_eq("tmr_pc", exception_PC, 32'h204);
    check_eq("tmr_addr", exception_addr, 0);
    check_eq("tmr_no_ack", exc_ack, 0);
    step();
    check_eq("tmr_redir_pc", redirect_pc, 32'h80);
    step();
    check_eq("tmr2_hold", pipeline_hold, 0);
    step();
    check_eq("tmr2_activate", activate_exception, 0);

    // Nested exception with redirect backpressure
    mtip_in = 0; exc_req = 1; exc_code = 4; exc_pc = 32'h400; exc_addr = 32'h44; redirect_ready = 0;
    step();
    check_eq("nest_activate", activate_exception, 1);
    check_eq("nest_code", exception_code, 4);
    exc_req = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", redirect_valid, 1);
      check_eq("bp_pc", redirect_pc, 32'h80);
      check_eq("bp_hold", pipeline_hold, 1);
      step();
    end
    redirect_ready = 1;
    step();
    check_eq("bp_release", redirect_valid, 0);
    mepc_in = 32'h204; mret_req = 1;
    step();
    mret_req = 0;
    step(); step();

    // Priority: ecall beats meip and mtip
    meie_in = 1; meip_in = 1; mtip_in = 1;
    exc_req = 1; exc_code = 11; exc_pc = 32'h500; exc_addr = 0;
    step();
    check_eq("pri_is_int", is_interrupt, 0);
    check_eq("pri_code", exception_code, 11);
    check_eq("pri_pc", exception_PC, 32'h500);
    check_eq("pri_ack", exc_ack, 1);
    exc_req = 0;
    step(); step();
    mret_req = 1;
    step();
    mret_req = 0;
    step(); step(); step();
    check_eq("ext_activate", activate_exception, 1);
    check_eq("ext_is_int", is_interrupt, 1);
    check_eq("ext_code", exception_code, 11);
    check_eq("ext_pc", exception_PC, 32'h204);
    redirect_ready = 0;
    step();
    check_eq("ext_valid", redirect_valid, 1);

    // Reset in REDIRECT
    sync_reset = 1;
    step();
    check_eq("rr_valid", redirect_valid, 0);
    check_eq("rr_pc", redirect_pc, 0);
    check_eq("rr_hold", pipeline_hold, 0);
    check_eq("rr_activate", activate_exception, 0);
    check_eq("rr_is_int", is_interrupt, 0);
    check_eq("rr_code", exception_code, 0);

    // Vectored mtvec
    meie_in = 0; meip_in = 0; mtvec_in = 32'h81; redirect_ready = 1;
    sync_reset = 0;
    step();
    check_eq("vec_code", exception_code, 7);
    step();
`ifdef TRAP_VECTORED_MTVEC_EN
    check_eq("vec_irq_pc", redirect_pc, 32'h9C);
`else
    check_eq("vec_irq_pc", redirect_pc, 32'h80);
`endif
    step();
    exc_req = 1; exc_code = 3; exc_pc = 32'h600;
    step();
    exc_req = 0;
    step();
    check_eq("vec_exc_pc", redirect_pc, 32'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
